axon_spike_decoder: RTL and testbench
=====================================

// Module: axon_spike_decoder
// PURPOSE
//  Upstream feeder of the core token controller. Accepts incoming axon spikes from the router,
//  buffers them in a circular FIFO, and releases each tick's batch on the following tick.
//  Serves one axon number per controller request via decoder_empty/read_spike/axon_number_valid.
// PARAMETERS
//  NUM_AXONS   256  axons per core; AXON_W = $clog2(NUM_AXONS)
//  FIFO_DEPTH  256  spike buffer entries; power of 2; PTR_W = $clog2(FIFO_DEPTH)
//  DROP_CNT_W  16   width of dropped-spike counter
// PORTS
//  clk               in   1        clock
//  rst               in   1        reset, synchronous, active-high
//  tick              in   1        1-cycle pulse: end of time step, releases buffered spikes
//  spike_valid_in    in   1        router spike present
//  spike_axon_in     in   AXON_W   destination axon of incoming spike
//  spike_ready_out   out  1        buffer can accept (= !full)
//  read_spike        in   1        controller request (level, may stay high several cycles)
//  decoder_empty     out  1        no released spike available
//  axon_number_out   out  AXON_W   axon number served to controller
//  axon_number_valid out  1        1-cycle strobe: axon_number_out valid
//  overflow          out  1        sticky: a spike was dropped while full
//  drop_count        out  DROP_CNT_W  dropped spikes, saturating
// BEHAVIOUR
//  Reset: all pointers 0, spike_ready_out=1, decoder_empty=1, axon_number_out=0,
//   axon_number_valid=0, overflow=0, drop_count=0, read_spike_q=0. Reset mid-operation discards
//   all buffered and released spikes; a pending strobe is cancelled.
//  Pointers wr_ptr, rel_ptr, rd_ptr are PTR_W+1 bits (wrap bit). full = wr_ptr-rd_ptr==FIFO_DEPTH.
//  Write: spike_valid_in && !full -> mem[wr_ptr]<=spike_axon_in, wr_ptr++ at clock edge.
//  Drop: spike_valid_in && full -> no write, overflow<=1, drop_count++ (saturates at all-ones).
//  Tick: rel_ptr <= wr_ptr value BEFORE any same-cycle write; spike written in the tick cycle
//   belongs to the next step. Tick with nothing buffered leaves state unchanged.
//  decoder_empty = (rd_ptr == rel_ptr); registered-equivalent, valid the cycle after pointer update.
//  Request: pop on rising edge of read_spike (read_spike && !read_spike_q) with !decoder_empty:
//   next edge axon_number_out<=mem[rd_ptr], axon_number_valid<=1, rd_ptr++. Latency 1 cycle.
//   axon_number_valid is high exactly 1 cycle; axon_number_out holds value until next pop.
//  read_spike held high after a pop causes no further pops; a new pop needs a low->high edge.
//  Rising edge while decoder_empty: ignored, no strobe, no pointer change (not queued).
//  Simultaneous write + pop: both occur; full computed from pre-edge pointers.
//  Simultaneous tick + pop: pop uses old rel_ptr; rel_ptr update independent of rd_ptr.
//  Pointer wrap: natural modulo 2^(PTR_W+1); no special case.
//  Invariant rd_ptr <= rel_ptr <= wr_ptr (mod wrap); assertion in bench.
// STRUCTURE
//  Shared package core_pkg: AXON_W derivation, axon_t typedef, FIFO_DEPTH default.
//  Sub-module spike_fifo_mem: simple dual-port RAM (1 write, 1 registered read), FIFO_DEPTH x AXON_W;
//   pointer/release/handshake logic stays in axon_spike_decoder.
// TESTING
//  1. Write axons 5,9,17 then tick; controller-style requests -> strobes with 5,9,17 in order,
//     decoder_empty=1 after third pop; before tick decoder_empty stays 1.
//  2. read_spike held high 4 cycles with 2 released -> exactly one strobe (first axon), one pop.
//  3. Fill FIFO_DEPTH spikes, send 3 more -> spike_ready_out=0, drop_count=3, overflow=1; tick and
//     drain -> all FIFO_DEPTH entries out in order, ready returns 1 after first pop.
//  4. Write axon 7 in same cycle as tick -> 7 not released until next tick (decoder_empty=1).
//  5. Release 2, pop 1, assert rst mid-strobe -> all outputs at reset values next cycle, empty=1.
//  6. Wrap: 3 x FIFO_DEPTH spikes across ticks with concurrent write/pop -> no loss, order kept.

Source files
------------

// File: rtl/core_pkg.sv
// Purpose : shared constants and types for the neuromorphic core datapath.
// Latency : n/a (package only).
// Backpressure: n/a.
// Contents: default core sizing, axon index width and type.
package core_pkg;

   localparam int DEF_NUM_AXONS  = 256;
   localparam int DEF_FIFO_DEPTH = 256;
   localparam int DEF_DROP_CNT_W = 16;

   localparam int DEF_AXON_W = $clog2(DEF_NUM_AXONS);

   typedef logic [DEF_AXON_W-1:0] axon_t;

endpackage

// File: rtl/spike_fifo_mem.sv
// Purpose : simple dual-port spike storage, one write port, one registered read port.
// Latency : read data appears on rd_dat one clock after rd_en; holds until the next rd_en.
// Backpressure: none; the owner guarantees it never reads an address being written.
// Ports   : clk/rst (sync, active-high, resets only the read register),
//           wr_en/wr_addr/wr_dat write port, rd_en/rd_addr read request, rd_dat read data.
module spike_fifo_mem #(
   parameter int DEPTH  = 256,
   parameter int WIDTH  = 8,
   localparam int ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [WIDTH-1:0]  wr_dat,
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [WIDTH-1:0]  rd_dat
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] rd_dat_q;
   logic [WIDTH-1:0] rd_dat_d;

   // Read register only loads on a request, so the served value persists.
   always_comb begin
      rd_dat_d = rd_dat_q;
      if (rd_en) begin
         rd_dat_d = mem_q[rd_addr];
      end
   end

   // Storage array carries no reset; stale contents are never visible
   // because the pointers gate every read.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_q[wr_addr] <= wr_dat;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_dat_q <= '0;
      end else begin
         rd_dat_q <= rd_dat_d;
      end
   end

   assign rd_dat = rd_dat_q;

endmodule

// File: rtl/axon_spike_decoder.sv
// Purpose : buffers router spikes, releases each time step's batch on tick, serves one axon per request.
// Latency : one clock from a read_spike rising edge to the axon_number_valid strobe.
// Backpressure: spike_ready_out drops when the buffer is full; spikes offered while full are counted and dropped.
// Ports   : clk, rst (sync, active-high), tick; router side spike_valid_in/spike_axon_in/spike_ready_out;
//           controller side read_spike/decoder_empty/axon_number_out/axon_number_valid; overflow, drop_count status.
module axon_spike_decoder
   import core_pkg::*;
#(
   parameter int  NUM_AXONS  = DEF_NUM_AXONS,
   parameter int  FIFO_DEPTH = DEF_FIFO_DEPTH,
   parameter int  DROP_CNT_W = DEF_DROP_CNT_W,
   localparam int AXON_W     = $clog2(NUM_AXONS),
   localparam int PTR_W      = $clog2(FIFO_DEPTH)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  tick,
   input  logic                  spike_valid_in,
   input  logic [AXON_W-1:0]     spike_axon_in,
   output logic                  spike_ready_out,
   input  logic                  read_spike,
   output logic                  decoder_empty,
   output logic [AXON_W-1:0]     axon_number_out,
   output logic                  axon_number_valid,
   output logic                  overflow,
   output logic [DROP_CNT_W-1:0] drop_count
);

   localparam logic [PTR_W:0]      PTR_ONE = {{PTR_W{1'b0}}, 1'b1};
   localparam logic [DROP_CNT_W-1:0] CNT_ONE = {{(DROP_CNT_W-1){1'b0}}, 1'b1};

   // Three pointers with an extra wrap bit: rd_ptr..rel_ptr is released,
   // rel_ptr..wr_ptr is buffered for the current time step.
   logic [PTR_W:0]        wr_ptr_q,  wr_ptr_d;
   logic [PTR_W:0]        rel_ptr_q, rel_ptr_d;
   logic [PTR_W:0]        rd_ptr_q,  rd_ptr_d;
   logic                  read_spike_q, read_spike_d;
   logic                  valid_q, valid_d;
   logic                  overflow_q, overflow_d;
   logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;

   logic full;
   logic empty;
   logic wr_en;
   logic pop;

   always_comb begin
      // Occupancy equals FIFO_DEPTH exactly when the wrap bits differ and the
      // index bits match.
      full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
              (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
      empty = (rd_ptr_q == rel_ptr_q);
      wr_en = spike_valid_in && !full;
      // Only a low-to-high request edge pops; a held level or an edge while
      // empty is ignored.
      pop   = read_spike && !read_spike_q && !empty;

      wr_ptr_d     = wr_ptr_q;
      rel_ptr_d    = rel_ptr_q;
      rd_ptr_d     = rd_ptr_q;
      overflow_d   = overflow_q;
      drop_cnt_d   = drop_cnt_q;
      valid_d      = pop;
      read_spike_d = read_spike;

      if (wr_en) begin
         wr_ptr_d = wr_ptr_q + PTR_ONE;
      end

      if (spike_valid_in && full) begin
         overflow_d = 1'b1;
         if (drop_cnt_q != {DROP_CNT_W{1'b1}}) begin
            drop_cnt_d = drop_cnt_q + CNT_ONE;
         end
      end

      // Release boundary uses the pre-write pointer, so a spike arriving in
      // the tick cycle belongs to the next time step.
      if (tick) begin
         rel_ptr_d = wr_ptr_q;
      end

      if (pop) begin
         rd_ptr_d = rd_ptr_q + PTR_ONE;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q     <= '0;
         rel_ptr_q    <= '0;
         rd_ptr_q     <= '0;
         read_spike_q <= 1'b0;
         valid_q      <= 1'b0;
         overflow_q   <= 1'b0;
         drop_cnt_q   <= '0;
      end else begin
         wr_ptr_q     <= wr_ptr_d;
         rel_ptr_q    <= rel_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         read_spike_q <= read_spike_d;
         valid_q      <= valid_d;
         overflow_q   <= overflow_d;
         drop_cnt_q   <= drop_cnt_d;
      end
   end

   // The memory read register doubles as the axon_number_out holding register.
   spike_fifo_mem #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (AXON_W)
   ) u_mem (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (wr_en),
      .wr_addr (wr_ptr_q[PTR_W-1:0]),
      .wr_dat  (spike_axon_in),
      .rd_en   (pop),
      .rd_addr (rd_ptr_q[PTR_W-1:0]),
      .rd_dat  (axon_number_out)
   );

   assign spike_ready_out   = !full;
   assign decoder_empty     = empty;
   assign axon_number_valid = valid_q;
   assign overflow          = overflow_q;
   assign drop_count        = drop_cnt_q;

endmodule

// File: tb/tb_axon_spike_decoder.sv
// Purpose : self-checking bench for axon_spike_decoder with a queue-based reference model.
// Latency : outputs sampled 1 time unit after each rising clock edge.
// Backpressure: full/drop behaviour exercised by overfilling the buffer.
module tb_axon_spike_decoder;

   localparam int DEPTH = 256;

   logic        clk = 1'b0;
   logic        rst;
   logic        tick;
   logic        spike_valid_in;
   logic [7:0]  spike_axon_in;
   logic        spike_ready_out;
   logic        read_spike;
   logic        decoder_empty;
   logic [7:0]  axon_number_out;
   logic        axon_number_valid;
   logic        overflow;
   logic [15:0] drop_count;

   int checks = 0;
   int errors = 0;

   // Reference model: spikes of the current step, spikes released to the controller.
   int pend[$];
   int avail[$];
   int m_out;
   bit m_vld;
   bit m_ovf;
   int m_drop;
   bit m_prev_rs;

   typedef struct {
      bit t;
      bit v;
      int ax;
      bit rs;
      bit e_rdy;
      bit e_emp;
      bit e_vld;
      int e_out;
   } vec_t;

   vec_t tbl[22];

   always #5 clk = ~clk;

   axon_spike_decoder dut (
      .clk               (clk),
      .rst               (rst),
      .tick              (tick),
      .spike_valid_in    (spike_valid_in),
      .spike_axon_in     (spike_axon_in),
      .spike_ready_out   (spike_ready_out),
      .read_spike        (read_spike),
      .decoder_empty     (decoder_empty),
      .axon_number_out   (axon_number_out),
      .axon_number_valid (axon_number_valid),
      .overflow          (overflow),
      .drop_count        (drop_count)
   );

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_step(input bit r, input bit t, input bit v, input int ax, input bit rs);
      bit full;
      if (r) begin
         pend.delete();
         avail.delete();
         m_out = 0;
         m_vld = 0;
         m_ovf = 0;
         m_drop = 0;
         m_prev_rs = 0;
      end else begin
         full  = (pend.size() + avail.size()) == DEPTH;
         m_vld = 0;
         if (rs && !m_prev_rs && avail.size() > 0) begin
            m_out = avail.pop_front();
            m_vld = 1;
         end
         if (t) begin
            while (pend.size() > 0) avail.push_back(pend.pop_front());
         end
         if (v) begin
            if (!full) pend.push_back(ax);
            else begin
               m_ovf = 1;
               if (m_drop < 65535) m_drop++;
            end
         end
         m_prev_rs = rs;
      end
   endtask

   task automatic check_model();
      logic [8:0] rel_occ;
      logic [8:0] tot_occ;
      chk("ready", int'(spike_ready_out), int'((pend.size() + avail.size()) < DEPTH));
      chk("empty", int'(decoder_empty), int'(avail.size() == 0));
      chk("valid", int'(axon_number_valid), int'(m_vld));
      chk("axon_out", int'(axon_number_out), m_out);
      chk("overflow", int'(overflow), int'(m_ovf));
      chk("drop_count", int'(drop_count), m_drop);
      // Pointer ordering invariant rd <= rel <= wr, in wrap arithmetic.
      rel_occ = dut.rel_ptr_q - dut.rd_ptr_q;
      tot_occ = dut.wr_ptr_q - dut.rd_ptr_q;
      chk("ptr_order", int'(rel_occ <= tot_occ && tot_occ <= 9'd256), 1);
   endtask

   task automatic cycle(input bit r, input bit t, input bit v, input int ax, input bit rs);
      rst            = r;
      tick           = t;
      spike_valid_in = v;
      spike_axon_in  = ax[7:0];
      read_spike     = rs;
      @(posedge clk);
      model_step(r, t, v, ax, rs);
      #1;
      check_model();
   endtask

   initial begin
      rst = 1'b1;
      tick = 1'b0;
      spike_valid_in = 1'b0;
      spike_axon_in = '0;
      read_spike = 1'b0;

      //            t  v  ax  rs  rdy emp vld out
      tbl[0]  = '{0, 1, 5,  0,  1,  1,  0,  0};
      tbl[1]  = '{0, 1, 9,  0,  1,  1,  0,  0};
      tbl[2]  = '{0, 1, 17, 0,  1,  1,  0,  0};
      tbl[3]  = '{0, 0, 0,  1,  1,  1,  0,  0};  // edge while empty: ignored
      tbl[4]  = '{0, 0, 0,  0,  1,  1,  0,  0};
      tbl[5]  = '{1, 0, 0,  0,  1,  0,  0,  0};  // release 5,9,17
      tbl[6]  = '{0, 0, 0,  1,  1,  0,  1,  5};
      tbl[7]  = '{0, 0, 0,  0,  1,  0,  0,  5};
      tbl[8]  = '{0, 0, 0,  1,  1,  0,  1,  9};
      tbl[9]  = '{0, 0, 0,  0,  1,  0,  0,  9};
      tbl[10] = '{0, 0, 0,  1,  1,  1,  1,  17};
      tbl[11] = '{1, 1, 7,  0,  1,  1,  0,  17}; // 7 written in tick cycle stays buffered
      tbl[12] = '{1, 0, 0,  0,  1,  0,  0,  17};
      tbl[13] = '{0, 1, 3,  0,  1,  0,  0,  17};
      tbl[14] = '{1, 0, 0,  0,  1,  0,  0,  17};
      tbl[15] = '{0, 0, 0,  1,  1,  0,  1,  7};  // held high four cycles: one pop
      tbl[16] = '{0, 0, 0,  1,  1,  0,  0,  7};
      tbl[17] = '{0, 0, 0,  1,  1,  0,  0,  7};
      tbl[18] = '{0, 0, 0,  1,  1,  0,  0,  7};
      tbl[19] = '{0, 0, 0,  0,  1,  0,  0,  7};
      tbl[20] = '{0, 0, 0,  1,  1,  1,  1,  3};
      tbl[21] = '{0, 0, 0,  0,  1,  1,  0,  3};

      // Reset state
      cycle(1, 0, 0, 0, 0);
      cycle(1, 0, 0, 0, 0);
      chk("rst_ready", int'(spike_ready_out), 1);
      chk("rst_empty", int'(decoder_empty), 1);
      chk("rst_valid", int'(axon_number_valid), 0);
      chk("rst_out", int'(axon_number_out), 0);
      chk("rst_drop", int'(drop_count), 0);

      // Directed table: ordering, held request, tick/write collision
      for (int i = 0; i < 22; i++) begin
         cycle(0, tbl[i].t, tbl[i].v, tbl[i].ax, tbl[i].rs);
         chk($sformatf("tbl%0d_ready", i), int'(spike_ready_out), int'(tbl[i].e_rdy));
         chk($sformatf("tbl%0d_empty", i), int'(decoder_empty), int'(tbl[i].e_emp));
         chk($sformatf("tbl%0d_valid", i), int'(axon_number_valid), int'(tbl[i].e_vld));
         chk($sformatf("tbl%0d_out", i), int'(axon_number_out), tbl[i].e_out);
      end

      // Reset in the middle of a strobe
      cycle(0, 0, 1, 11, 0);
      cycle(0, 0, 1, 12, 0);
      cycle(0, 1, 0, 0, 0);
      cycle(0, 0, 0, 0, 1);
      chk("pre_rst_valid", int'(axon_number_valid), 1);
      chk("pre_rst_out", int'(axon_number_out), 11);
      cycle(1, 0, 0, 0, 1);
      chk("mid_rst_valid", int'(axon_number_valid), 0);
      chk("mid_rst_out", int'(axon_number_out), 0);
      chk("mid_rst_empty", int'(decoder_empty), 1);
      cycle(0, 0, 0, 0, 0);
      cycle(0, 0, 0, 0, 1);
      chk("post_rst_no_pop", int'(axon_number_valid), 0);
      cycle(0, 0, 0, 0, 0);

      // Fill to capacity, overfill by three, then drain
      for (int i = 0; i < DEPTH; i++) cycle(0, 0, 1, (i * 7 + 1) % 256, 0);
      chk("full_ready", int'(spike_ready_out), 0);
      for (int i = 0; i < 3; i++) cycle(0, 0, 1, 99, 0);
      chk("ovf_drop", int'(drop_count), 3);
      chk("ovf_sticky", int'(overflow), 1);
      chk("ovf_ready", int'(spike_ready_out), 0);
      cycle(0, 1, 0, 0, 0);
      for (int i = 0; i < DEPTH; i++) begin
         cycle(0, 0, 0, 0, 1);
         if (i == 0) chk("ready_after_pop", int'(spike_ready_out), 1);
         cycle(0, 0, 0, 0, 0);
      end
      chk("drained_empty", int'(decoder_empty), 1);
      chk("drained_last", int'(axon_number_out), ((DEPTH - 1) * 7 + 1) % 256);
      cycle(1, 0, 0, 0, 0);

      // Randomized traffic with concurrent write/pop/tick, several wraps
      for (int i = 0; i < 4000; i++) begin
         cycle(0, ($urandom_range(0, 15) == 0), ($urandom_range(0, 3) == 0),
               int'($urandom_range(0, 255)), bit'($urandom_range(0, 1)));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
